intpol2_d4_out_fifo: RTL and testbench
======================================

# intpol2_d4_out_fifo

Synchronous output FIFO directly downstream of the order-2 D4 interpolator control/datapath. It buffers interpolated samples written by the interpolator (`wr_en` driven by the interpolator's Write_Enable), returns `Afull` to stall it, and presents samples to the sink through a registered-read port. Clearing is synchronous and driven by the interpolator's `clear` (start/done) pulse.

## Interface
- `DW`, 16, sample width in bits.
- `AW`, 4, address width; DEPTH = 2^AW entries.
- `AFULL_MARGIN`, 2, Afull asserts when free entries <= AFULL_MARGIN; legal range 1..DEPTH-1.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `clear`  in  1  synchronous flush, one or more cycles.
- `wr_en`  in  1  write request.
- `wdata`  in  DW  write sample, two's complement, stored unmodified.
- `rd_en`  in  1  read request from sink.
- `rdata`  out  DW  registered read sample.
- `rvalid`  out  1  one-cycle pulse: `rdata` updated this cycle.
- `Empty`  out  1  count == 0.
- `Full`  out  1  count == DEPTH.
- `Afull`  out  1  count >= DEPTH - AFULL_MARGIN.
- `count`  out  AW+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: write dropped because Full.
- `underflow`  out  1  sticky: read ignored because Empty.

## Operation
- Storage: DEPTH x DW register array, not reset. Write pointer `wp`, read pointer `rp` (AW bits, natural wrap DEPTH-1 -> 0), occupancy `count` (AW+1 bits).
- Accept rules, evaluated on pre-edge state:
  - wr_acc = wr_en & ~Full; rd_acc = rd_en & ~Empty.
  - Write at Full is dropped, even with a simultaneous accepted read; sets `overflow`.
  - Read at Empty is ignored, even with a simultaneous write; sets `underflow`; `rvalid` stays 0.
- On wr_acc: mem[wp] <= wdata, wp <= wp+1.
- On rd_acc: rdata <= mem[rp], rvalid <= 1, rp <= rp+1; otherwise rvalid <= 0 and rdata holds.
- count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Empty, Full, Afull: combinational decodes of registered `count` (no extra latency, glitch-free from flops). Upstream samples Afull combinationally in the same cycle it asserts Write_Enable, so AFULL_MARGIN >= 1 guarantees no overflow in normal flow.
- clear (priority over wr_en/rd_en): wp, rp, count <= 0; rvalid <= 0; overflow, underflow <= 0; rdata holds; memory untouched.
- Reset (async assert, sync release on clk): wp=rp=0, count=0, rdata=0, rvalid=0, overflow=0, underflow=0, so Empty=1, Full=0, Afull=0.
- Sticky flags clear only via `rst` or `clear`.

## Timing
- Write latency: wdata presented with wr_en in cycle k is readable from cycle k+1 (Empty falls in k+1).
- Read latency: rd_en accepted in cycle k -> rdata/rvalid valid in cycle k+1; back-to-back reads give one sample per cycle.
- Throughput: one write and one read per cycle concurrently, including at count=1 (old word read, new word stored) and count=DEPTH-1.
- Flags update one cycle after the causing edge; `overflow`/`underflow` assert in the cycle after the offending request.
- clear in cycle k: Empty=1, count=0, rvalid=0 in k+1; a wr_en in cycle k is discarded.
- Reset asserted mid-operation: all outputs take reset values immediately (asynchronously); pending requests lost.

## Test plan
- Reset then idle: rst high 3 cycles -> Empty=1, Full=0, Afull=0, count=0, rdata=0, rvalid=0, flags 0.
- Fill: 14 writes of 0x0001..0x000E (defaults) -> Afull rises the cycle after write 14 (count=14); writes 15,16 -> Full=1, count=16; Afull stays high.
- Overflow: at Full, write 0x7FFF with simultaneous rd_en -> read returns 0x0001 next cycle, count=15, 0x7FFF not stored, overflow=1.
- Wrap-around ordering: 40 writes of 0x8000+i interleaved with reads, occupancy 1..16 -> reads return 0x8000..0x8027 in order, one rvalid per accepted read, no flags set.
- Underflow: rd_en at Empty with simultaneous write 0x1234 -> rvalid=0, underflow=1, count=1; next rd_en -> rdata=0x1234, rvalid=1.
- Clear mid-stream: count=9, overflow=1, clear + wr_en in same cycle -> next cycle count=0, Empty=1, overflow=0; next write 0x00AA then read returns 0x00AA.

Source files
------------

// File: rtl/intpol2_d4_out_fifo_if.sv
// Sample/handshake bundle between the D4 interpolator (master) and its output FIFO (slave).
// The sink-side read port and the status flags share the same bundle.
interface intpol2_d4_out_fifo_if #(
   parameter int DW = 16,
   parameter int AW = 4
) ();
   logic          clear;
   logic          wr_en;
   logic [DW-1:0] wdata;
   logic          rd_en;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          Empty;
   logic          Full;
   logic          Afull;
   logic [AW:0]   count;
   logic          overflow;
   logic          underflow;

   modport master (
      output clear, wr_en, wdata, rd_en,
      input  rdata, rvalid, Empty, Full, Afull, count, overflow, underflow
   );

   modport slave (
      input  clear, wr_en, wdata, rd_en,
      output rdata, rvalid, Empty, Full, Afull, count, overflow, underflow
   );
endinterface

// File: rtl/intpol2_d4_out_fifo.sv
// Output FIFO behind the order-2 D4 interpolator: registered read port, occupancy-decoded
// Empty/Full/Afull, sticky overflow/underflow, synchronous flush via clear.
module intpol2_d4_out_fifo #(
   parameter int DW           = 16,
   parameter int AW           = 4,
   parameter int AFULL_MARGIN = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   intpol2_d4_out_fifo_if.slave   bus
);
   localparam int          DEPTH       = 1 << AW;
   localparam logic [AW:0] FULL_LEVEL  = (AW + 1)'(DEPTH);
   localparam logic [AW:0] AFULL_LEVEL = (AW + 1)'(DEPTH - AFULL_MARGIN);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic [AW:0]   count;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          overflow;
   logic          underflow;
   logic          empty;
   logic          full;
   logic          afull;
   logic          wr_acc;
   logic          rd_acc;

   // Flags decode the registered count only, so they are glitch-free and need no extra flops.
   assign empty  = (count == '0);
   assign full   = (count == FULL_LEVEL);
   assign afull  = (count >= AFULL_LEVEL);
   assign wr_acc = bus.wr_en & ~full;
   assign rd_acc = bus.rd_en & ~empty;

   // NOTE: the sample array has no reset; every word is written before it can be read,
   // and leaving it out of reset lets it map onto plain storage.
   always_ff @(posedge clk) begin
      if (wr_acc && !bus.clear) begin
         mem[wp] <= bus.wdata;
      end
   end

   // NOTE: all state below uses non-blocking assignments so every decision reads
   // pre-edge values, matching the accept rules on count, wp and rp.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         rdata     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.clear) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         rvalid    <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_acc) begin
            wp <= wp + 1'b1;
         end
         if (rd_acc) begin
            rdata <= mem[rp];
            rp    <= rp + 1'b1;
         end
         rvalid <= rd_acc;

         unique case ({wr_acc, rd_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (bus.wr_en && full) begin
            overflow <= 1'b1;
         end
         if (bus.rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end

   assign bus.rdata     = rdata;
   assign bus.rvalid    = rvalid;
   assign bus.Empty     = empty;
   assign bus.Full      = full;
   assign bus.Afull     = afull;
   assign bus.count     = count;
   assign bus.overflow  = overflow;
   assign bus.underflow = underflow;
endmodule

// File: tb/tb_intpol2_d4_out_fifo.sv
// Bench for intpol2_d4_out_fifo: vector table, directed corner sequences and random traffic,
// all compared against a queue-based model of the FIFO behaviour.
module tb_intpol2_d4_out_fifo;
   localparam int DW     = 16;
   localparam int AW     = 4;
   localparam int DEPTH  = 16;
   localparam int MARGIN = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   intpol2_d4_out_fifo_if #(.DW(DW), .AW(AW)) bus ();

   intpol2_d4_out_fifo #(.DW(DW), .AW(AW), .AFULL_MARGIN(MARGIN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural model: the FIFO contents as a queue plus the visible registered outputs.
   logic [DW-1:0] q [$];
   logic [DW-1:0] m_rdata;
   logic          m_rvalid;
   logic          m_ovf;
   logic          m_unf;

   typedef struct {
      logic          clr;
      logic          wr;
      logic [DW-1:0] wd;
      logic          rd;
      logic [AW:0]   e_count;
      logic [DW-1:0] e_rdata;
      logic          e_rvalid;
      logic          e_ovf;
      logic          e_unf;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_rdata  = '0;
      m_rvalid = 1'b0;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
   endtask

   task automatic model_step(input logic c, input logic w, input logic [DW-1:0] wd, input logic r);
      bit was_full;
      bit was_empty;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (c) begin
         q.delete();
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_unf    = 1'b0;
      end else begin
         m_rvalid = r && !was_empty;
         if (m_rvalid) m_rdata = q.pop_front();
         if (w && !was_full) q.push_back(wd);
         if (w && was_full) m_ovf = 1'b1;
         if (r && was_empty) m_unf = 1'b1;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, " count"},     32'(bus.count),     32'(q.size()));
      check({tag, " Empty"},     32'(bus.Empty),     32'(q.size() == 0));
      check({tag, " Full"},      32'(bus.Full),      32'(q.size() == DEPTH));
      check({tag, " Afull"},     32'(bus.Afull),     32'(q.size() >= DEPTH - MARGIN));
      check({tag, " rdata"},     32'(bus.rdata),     32'(m_rdata));
      check({tag, " rvalid"},    32'(bus.rvalid),    32'(m_rvalid));
      check({tag, " overflow"},  32'(bus.overflow),  32'(m_ovf));
      check({tag, " underflow"}, 32'(bus.underflow), 32'(m_unf));
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
   task automatic cycle(input logic c, input logic w, input logic [DW-1:0] wd, input logic r,
                        input string tag);
      bus.clear = c;
      bus.wr_en = w;
      bus.wdata = wd;
      bus.rd_en = r;
      model_step(c, w, wd, r);
      @(posedge clk);
      #1;
      bus.clear = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      check_model(tag);
   endtask

   initial begin
      int exp_next;
      int phase;
      logic w, r, c;

      tbl[0] = '{1'b0, 1'b1, 16'h1234, 1'b1, 5'd1, 16'h0000, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b0, 16'h0000, 1'b1, 5'd0, 16'h1234, 1'b1, 1'b0, 1'b1};
      tbl[2] = '{1'b0, 1'b1, 16'h0055, 1'b0, 5'd1, 16'h1234, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b0, 1'b1, 16'h0066, 1'b1, 5'd1, 16'h0055, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 16'h0077, 1'b1, 5'd0, 16'h0055, 1'b0, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 16'h00AA, 1'b0, 5'd1, 16'h0055, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b1, 5'd0, 16'h00AA, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 5'd0, 16'h00AA, 1'b0, 1'b0, 1'b0};

      bus.clear = 1'b0;
      bus.wr_en = 1'b0;
      bus.wdata = '0;
      bus.rd_en = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_model("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_model("idle");

      // Underflow, concurrent access at count=1 and clear priority, from the vector table.
      for (int i = 0; i < 8; i++) begin
         cycle(tbl[i].clr, tbl[i].wr, tbl[i].wd, tbl[i].rd, $sformatf("vec%0d", i));
         check($sformatf("vec%0d count", i),  32'(bus.count),     32'(tbl[i].e_count));
         check($sformatf("vec%0d rdata", i),  32'(bus.rdata),     32'(tbl[i].e_rdata));
         check($sformatf("vec%0d rvalid", i), 32'(bus.rvalid),    32'(tbl[i].e_rvalid));
         check($sformatf("vec%0d ovf", i),    32'(bus.overflow),  32'(tbl[i].e_ovf));
         check($sformatf("vec%0d unf", i),    32'(bus.underflow), 32'(tbl[i].e_unf));
      end

      // Fill to Afull then Full.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b0, 1'b1, DW'(i), 1'b0, "fill");
         if (i == 13) check("fill13 Afull", 32'(bus.Afull), 32'd0);
         if (i == 14) check("fill14 Afull", 32'(bus.Afull), 32'd1);
      end
      check("full Full",  32'(bus.Full),  32'd1);
      check("full count", 32'(bus.count), 32'd16);
      check("full Afull", 32'(bus.Afull), 32'd1);

      // Write at Full with a simultaneous read: read proceeds, write dropped.
      cycle(1'b0, 1'b1, 16'h7FFF, 1'b1, "ovf");
      check("ovf rdata",    32'(bus.rdata),    32'h0001);
      check("ovf count",    32'(bus.count),    32'd15);
      check("ovf overflow", 32'(bus.overflow), 32'd1);
      for (int i = 2; i <= 7; i++) begin
         cycle(1'b0, 1'b0, '0, 1'b1, "drain6");
         check("drain6 rdata", 32'(bus.rdata), 32'(i));
      end

      // Clear mid-stream at count=9 with overflow set; the same-cycle write is discarded.
      cycle(1'b1, 1'b1, 16'h0BAD, 1'b0, "clr");
      check("clr count",    32'(bus.count),    32'd0);
      check("clr Empty",    32'(bus.Empty),    32'd1);
      check("clr overflow", 32'(bus.overflow), 32'd0);
      cycle(1'b0, 1'b1, 16'h00AA, 1'b0, "clr_wr");
      cycle(1'b0, 1'b0, '0, 1'b1, "clr_rd");
      check("clr_rd rdata",  32'(bus.rdata),  32'h00AA);
      check("clr_rd rvalid", 32'(bus.rvalid), 32'd1);

      // Wrap-around ordering: 40 words, occupancy between 1 and 16.
      exp_next = 0;
      for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 16'h8000 + DW'(i), 1'b0, "wrap_w");
      for (int i = 16; i < 40; i++) begin
         cycle(1'b0, 1'b0, '0, 1'b1, "wrap_r");
         if (bus.rvalid) begin
            check("wrap order", 32'(bus.rdata), 32'h8000 + 32'(exp_next));
            exp_next++;
         end
         cycle(1'b0, 1'b1, 16'h8000 + DW'(i), 1'b0, "wrap_w");
      end
      for (int i = 0; i < 16; i++) begin
         cycle(1'b0, 1'b0, '0, 1'b1, "wrap_d");
         if (bus.rvalid) begin
            check("wrap order", 32'(bus.rdata), 32'h8000 + 32'(exp_next));
            exp_next++;
         end
      end
      check("wrap reads",     32'(exp_next),      32'd40);
      check("wrap overflow",  32'(bus.overflow),  32'd0);
      check("wrap underflow", 32'(bus.underflow), 32'd0);

      // Random traffic in fill-biased, drain-biased and balanced phases.
      for (int i = 0; i < 3000; i++) begin
         phase = (i / 250) % 3;
         c = ($urandom_range(0, 149) == 0);
         case (phase)
            0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
            1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
            default: begin w = ($urandom_range(0, 1) == 1); r = ($urandom_range(0, 1) == 1); end
         endcase
         cycle(c, w, DW'($urandom), r, "rand");
      end

      // Asynchronous reset in the middle of a cycle with data queued.
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, DW'(16'h4000 + i), 1'b1, "pre_rst");
      cycle(1'b0, 1'b1, 16'h5555, 1'b0, "pre_rst");
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_model("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_model("rst_hold");
      cycle(1'b0, 1'b0, '0, 1'b1, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
